// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock, LSB first.
// Define SERIAL_ADD_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sum_bit;
    logic             carry_out;
    logic             last_bit;

    // Single full-adder cell shared by every bit position.
    assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_out = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last_bit  = (cnt == LAST);

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            S     <= '0;
            C     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= sub ? ~B : B;
                        carry <= sub;
                        psum  <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_out;
                    psum  <= {sum_bit, psum[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        S <= {sum_bit, psum[WIDTH-1:1]};
                        C <= carry_out;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    // On the last bit, the carry register holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state_q == RUN && last_bit) begin
            ovf <= carry ^ carry_out;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port sub, input, 1: 0 computes A+B, 1 computes A-B; sampled with start.
REQ-006 SHALL have port A, input, WIDTH, first operand; sampled with start.
REQ-007 SHALL have port B, input, WIDTH, second operand; sampled with start.
REQ-008 SHALL have port S, output, WIDTH, registered result of the last completed operation.
REQ-009 SHALL have port C, output, 1, registered carry-out of the last completed operation (for subtraction, 1 = no borrow).
REQ-010 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking the cycle in which S/C first hold a new result.
REQ-012 SHALL have port ovf, output, 1, signed-overflow flag (see Configuration).

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at an edge, SHALL load A into operand shift register a_sr, load B (sub=0) or ~B (sub=1) into b_sr, set carry register to sub, clear the bit counter, and go to RUN.
REQ-015 In RUN, each edge SHALL compute one sum bit and one carry from a_sr[0], b_sr[0] and carry using a single full-adder cell (XOR/AND/OR), shift the sum bit into the MSB of the partial-sum register, shift a_sr/b_sr right by one, and increment the counter.
REQ-016 After the WIDTH-th RUN edge, SHALL copy the partial sum to S, the final carry to C, and go to DONE.
REQ-017 Latency: start sampled at edge 0; S/C update at edge WIDTH; done=1 during the cycle after edge WIDTH; the FSM returns to IDLE at edge WIDTH+1.
REQ-018 busy SHALL be 1 in RUN and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-019 start SHALL be ignored in RUN and DONE; A, B and sub changes after the sampling edge SHALL NOT affect the result.
REQ-020 S, C and ovf SHALL hold their values between completions and SHALL NOT show partial results during RUN.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; C is bit WIDTH of A+B or of A+~B+1.
REQ-022 Back-to-back operations: start held high SHALL begin a new operation at the first edge in IDLE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-023 rst_n=0 SHALL immediately force the FSM to IDLE and clear S, C, ovf, busy, done, counter, carry and all shift registers to 0, including mid-operation.
REQ-024 The first start after rst_n deasserts SHALL be accepted at the first rising clk edge with rst_n=1.

Configuration
REQ-025 With macro SERIAL_ADD_SUB_OVF_EN defined, ovf SHALL be registered at edge WIDTH as (carry into the MSB) XOR (carry out of the MSB), reflecting two's-complement overflow of the operation.
REQ-026 Without SERIAL_ADD_SUB_OVF_EN, ovf SHALL be tied to 0 and no overflow logic SHALL be synthesised.

Verification (WIDTH=8)
REQ-027 start, sub=0, A=8'h3C, B=8'h0F -> done pulses the cycle after edge 8; S=8'h4B, C=0, ovf=0.
REQ-028 sub=0, A=8'hFF, B=8'h01 -> S=8'h00, C=1, ovf=0.
REQ-029 sub=1, A=8'h05, B=8'h07 -> S=8'hFE, C=0 (borrow), ovf=0.
REQ-030 sub=0, A=8'h7F, B=8'h01 -> S=8'h80, C=0; ovf=1 with SERIAL_ADD_SUB_OVF_EN, ovf=0 without it.
REQ-031 start pulsed again at edge 3 of a running operation with different A/B -> ignored; the result matches the first operands and busy stays high until edge 8.
REQ-032 rst_n low at edge 4 of an operation -> busy=0, done=0, S=0, C=0 immediately with no clk edge; the next start after release completes normally.
